// File: rtl/collect_2x1_one_hot_seq_pkg.sv
// Shared NoC definitions: source encodings for merged tags and outgoing tag width.
package collect_2x1_one_hot_seq_pkg;

  typedef enum logic {
    SRC_BUS  = 1'b0,
    SRC_NODE = 1'b1
  } src_e;

  // The outgoing tag prepends one source bit to the incoming tag.
  function automatic int out_cmd_width(input int in_width);
    return in_width + 1;
  endfunction

endpackage

// File: rtl/collect_2x1_one_hot_seq_if.sv
// Handshake bundle between the two sources, the collector and the next node.
interface collect_2x1_one_hot_seq_if
  import collect_2x1_one_hot_seq_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int IN_COMMAND_WIDTH  = 2,
  parameter int OUT_COMMAND_WIDTH = out_cmd_width(IN_COMMAND_WIDTH)
) ();

  logic                          i_en;
  logic [1:0]                    i_valid;
  logic [2*DATA_WIDTH-1:0]       i_data_bus;
  logic [2*IN_COMMAND_WIDTH-1:0] i_cmd;
  logic [1:0]                    o_ready;
  logic                          o_valid;
  logic [DATA_WIDTH-1:0]         o_data_bus;
  logic [OUT_COMMAND_WIDTH-1:0]  o_cmd;
  logic                          i_ready;

  modport master (
    output i_en, i_valid, i_data_bus, i_cmd, i_ready,
    input  o_ready, o_valid, o_data_bus, o_cmd
  );

  modport slave (
    input  i_en, i_valid, i_data_bus, i_cmd, i_ready,
    output o_ready, o_valid, o_data_bus, o_cmd
  );

endinterface

// File: rtl/collect_fifo.sv
// Per-input queue holding word and tag together; ready is registered so it never
// depends combinationally on the upstream valid or downstream ready.
module collect_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [CMD_WIDTH-1:0]  push_cmd,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CMD_WIDTH-1:0]  pop_cmd,
  output logic                  not_empty,
  output logic                  ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [CMD_WIDTH-1:0]  mem_cmd  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  ready_q;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      ready_q <= (count_next < CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_cmd[wr_ptr]  <= push_cmd;
    end
  end

  assign pop_data  = mem_data[rd_ptr];
  assign pop_cmd   = mem_cmd[rd_ptr];
  assign not_empty = (count != '0);
  assign ready     = ready_q;

endmodule

// File: rtl/collect_2x1_one_hot_seq.sv
// Two-input collector: queues node and bus words separately and merges them
// round-robin into one registered output tagged with the source bit.
module collect_2x1_one_hot_seq
  import collect_2x1_one_hot_seq_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int IN_COMMAND_WIDTH  = 2,
  parameter int OUT_COMMAND_WIDTH = out_cmd_width(IN_COMMAND_WIDTH),
  parameter int FIFO_DEPTH        = 2
) (
  input logic                      clk,
  input logic                      rst,
  collect_2x1_one_hot_seq_if.slave bus
);

  logic [DATA_WIDTH-1:0]        node_word, bus_word, out_data;
  logic [IN_COMMAND_WIDTH-1:0]  node_tag, bus_tag;
  logic                         node_ne, bus_ne, node_ready, bus_ready;
  logic                         node_push, bus_push, node_pop, bus_pop, load;
  logic                         out_valid;
  logic [OUT_COMMAND_WIDTH-1:0] out_cmd;
  src_e                         grant, last_grant;

  assign node_push = bus.i_en & bus.i_valid[1] & node_ready;
  assign bus_push  = bus.i_en & bus.i_valid[0] & bus_ready;

  collect_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .CMD_WIDTH  (IN_COMMAND_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_node_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (node_push),
    .push_data (bus.i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]),
    .push_cmd  (bus.i_cmd[2*IN_COMMAND_WIDTH-1:IN_COMMAND_WIDTH]),
    .pop       (node_pop),
    .pop_data  (node_word),
    .pop_cmd   (node_tag),
    .not_empty (node_ne),
    .ready     (node_ready)
  );

  collect_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .CMD_WIDTH  (IN_COMMAND_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_bus_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus_push),
    .push_data (bus.i_data_bus[DATA_WIDTH-1:0]),
    .push_cmd  (bus.i_cmd[IN_COMMAND_WIDTH-1:0]),
    .pop       (bus_pop),
    .pop_data  (bus_word),
    .pop_cmd   (bus_tag),
    .not_empty (bus_ne),
    .ready     (bus_ready)
  );

  // On contention the source not granted last wins; otherwise whoever has data.
  always_comb begin
    grant = SRC_BUS;
    if (node_ne && bus_ne)
      grant = (last_grant == SRC_NODE) ? SRC_BUS : SRC_NODE;
    else if (node_ne)
      grant = SRC_NODE;
  end

  assign load     = bus.i_en & (node_ne | bus_ne) & (~out_valid | bus.i_ready);
  assign node_pop = load & (grant == SRC_NODE);
  assign bus_pop  = load & (grant == SRC_BUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_cmd    <= '0;
      last_grant <= SRC_NODE;
    end else if (load) begin
      out_valid  <= 1'b1;
      last_grant <= grant;
      if (grant == SRC_NODE) begin
        out_data <= node_word;
        out_cmd  <= OUT_COMMAND_WIDTH'({SRC_NODE, node_tag});
      end else begin
        out_data <= bus_word;
        out_cmd  <= OUT_COMMAND_WIDTH'({SRC_BUS, bus_tag});
      end
    end else if (out_valid && bus.i_ready) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cmd   <= '0;
    end
  end

  assign bus.o_ready    = {node_ready, bus_ready};
  assign bus.o_valid    = out_valid;
  assign bus.o_data_bus = out_data;
  assign bus.o_cmd      = out_cmd;

endmodule

// File: doc/collect_2x1_one_hot_seq.md
COLLECT_2X1_ONE_HOT_SEQ -- requirements
Module: collect_2x1_one_hot_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one data word.
REQ-002 SHALL have parameter IN_COMMAND_WIDTH, default 2, width of each incoming tag.
REQ-003 SHALL have parameter OUT_COMMAND_WIDTH, default IN_COMMAND_WIDTH+1, width of the outgoing tag.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, entries per input queue; power of two, at least 2.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_en  input  1  switch enable; gates pushes and pops.
REQ-008 SHALL have port i_valid  input  2  {node, bus} input valid.
REQ-009 SHALL have port i_data_bus  input  2*DATA_WIDTH  {node word, bus word}.
REQ-010 SHALL have port i_cmd  input  2*IN_COMMAND_WIDTH  {node tag, bus tag}.
REQ-011 SHALL have port o_ready  output  2  {node, bus} input queue not full.
REQ-012 SHALL have port o_valid  output  1  output word valid.
REQ-013 SHALL have port o_data_bus  output  DATA_WIDTH  merged word to the next node.
REQ-014 SHALL have port o_cmd  output  OUT_COMMAND_WIDTH  {source bit, original tag}.
REQ-015 SHALL have port i_ready  input  1  downstream accepts the output word.

Function
REQ-016 Input k SHALL be pushed into its own FIFO when i_en && i_valid[k] && o_ready[k]; the word and tag are stored together.
REQ-017 o_ready[k] SHALL be 1 exactly when FIFO k holds fewer than FIFO_DEPTH entries; it is registered state, never a function of i_valid or i_ready.
REQ-018 The output register SHALL load when i_en && at least one FIFO is non-empty && (o_valid==0 || i_ready==1); it holds otherwise.
REQ-019 The output register SHALL pop one entry per load, chosen by round-robin: when both FIFOs are non-empty, grant goes to the source not granted last; when only one is non-empty, that source is granted.
REQ-020 The last-grant pointer SHALL update only on a load, and after reset SHALL favour bus on the first contention.
REQ-021 On a load, o_cmd SHALL be {1'b1, node tag} for a node pop and {1'b0, bus tag} for a bus pop; o_data_bus SHALL be the popped word unchanged.
REQ-022 When o_valid==1 && i_ready==1 and nothing is loaded, o_valid SHALL fall to 0 and o_data_bus and o_cmd SHALL go to all-zero.
REQ-023 Minimum latency SHALL be 2 cycles: an input accepted at edge N appears on o_valid after edge N+1; there is no FIFO bypass.
REQ-024 With o_valid==1 and i_ready==0, o_data_bus and o_cmd SHALL hold stable and no pop SHALL occur.
REQ-025 A push and a pop on the same FIFO in one cycle SHALL both take effect and leave the count unchanged.
REQ-026 With i_en==0, no push or pop SHALL occur; the output register holds, and a pending word is still consumed by i_ready.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.

Reset
REQ-028 While rst==1, both FIFOs SHALL be emptied, pointers set to 0, last-grant set to node (so bus wins first), o_valid=0, o_data_bus=0, o_cmd=0, and o_ready=2'b00.
REQ-029 o_ready SHALL be 2'b11 in the first cycle after rst deasserts; rst asserted mid-transfer SHALL discard all queued and output data, with no partial word emitted.

Structure
REQ-030 Source-bit encodings (NODE=1, BUS=0) and the OUT_COMMAND_WIDTH derivation SHALL live in the shared NoC package used by the distribute switches.
REQ-031 The per-input queue SHALL be one sub-module, collect_fifo (parameters DATA_WIDTH, CMD_WIDTH, FIFO_DEPTH), instantiated twice.

Verification
REQ-032 Scenario: bus only sends word 0xA5 with tag 2'b01, and i_ready=1 -> after 2 edges o_valid=1, o_data_bus=0xA5, o_cmd=3'b001.
REQ-033 Scenario: both inputs push for 4 cycles (node 0x10..0x13, bus 0x20..0x23), i_ready=1 -> output order is 0x20,0x10,0x21,0x11,..., with o_cmd MSB alternating 0,1.
REQ-034 Scenario: i_ready=0 while node pushes continuously -> after the output register plus FIFO_DEPTH words, o_ready[1]=0; o_data_bus stays stable; no word is lost once i_ready=1.
REQ-035 Scenario: FIFO full and i_ready pulses for 1 cycle -> o_ready rises the next cycle, and the next push is accepted without overflow.
REQ-036 Scenario: rst asserted with 2 words queued -> next cycle o_valid=0 and o_ready=2'b00; the cycle after rst falls o_ready=2'b11 and no stale word is emitted.
REQ-037 Scenario: i_en=0 with i_valid=2'b11 for 3 cycles -> no pushes, and the counts are unchanged.
